spi_mem_arbiter: RTL and testbench

- Shares one external SPI RAM (23LC-style, SPI mode 0) between two on-chip requesters, e.g. CPU instruction fetch (port 0) and CPU data load/store (port 1).
- Arbitrates requests with a valid/ready handshake and serialises each one as a complete single-byte READ (0x03) or WRITE (0x02) frame.
- Returns read data with a one-cycle response pulse tagged with the requester id.
- Sits between the CPU core and the uio SPI pins (cs_n, sck, mosi, miso).

---
 rtl/spi_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter serialising single-byte READ/WRITE frames to a 23LC-style SPI RAM (mode 0).
// Define SPI_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round robin.
module spi_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_wdata,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [7:0]        resp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N  = 16 + ADDR_W;
  localparam int BW = $clog2(N);
  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [CW-1:0] PH_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      tx_q, tx_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sck_q, sck_d;
  logic              we_q, we_d;
  logic              id_q, id_d;
  logic              resp_q, resp_d;
  logic              gnt1, idle, accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign gnt1 = req1_valid & ~req0_valid;
`else
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= gnt1;
  end

  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
`endif

  assign idle       = (state_q == IDLE) & ~rst;
  assign req1_ready = idle & gnt1;
  assign req0_ready = idle & req0_valid & ~gnt1;
  assign accept     = req0_ready | req1_ready;

  assign sel_we    = gnt1 ? req1_we    : req0_we;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sck_d   = sck_q;
    we_d    = we_q;
    id_d    = id_q;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // 0x02 write / 0x03 read; read data slot shifts out zeros
          tx_d    = {7'b0000001, ~sel_we, sel_addr,
                     sel_we ? sel_wdata : 8'h00};
          we_d    = sel_we;
          id_d    = gnt1;
          bit_d   = '0;
          cnt_d   = '0;
          sck_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == PH_END) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_q == LAST_BIT) begin
              state_d = GAP;
              resp_d  = 1'b1;
              if (!we_q) rdata_d = rx_q;
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = {tx_q[N-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_END) state_d = IDLE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sck_q   <= sck_d;
      we_q    <= we_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
    end
  end

  assign spi_cs_n   = (state_q != SHIFT);
  assign spi_sck    = sck_q;
  assign spi_mosi   = (state_q == SHIFT) & tx_q[N-1];
  assign busy       = (state_q != IDLE) | accept;
  assign resp_valid = resp_q;
  assign resp_id    = id_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench for spi_mem_arbiter: a CLK_DIV=2 and a CLK_DIV=1 instance,
// each attached to a behavioural SPI RAM.
`timescale 1ns/1ps
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic        r0v = 1'b0, r0w = 1'b0, r1v = 1'b0, r1w = 1'b0;
  logic        r0r, r1r;
  logic [15:0] r0a = '0, r1a = '0;
  logic [7:0]  r0d = '0, r1d = '0;
  logic        rv, rid, bsy;
  logic [7:0]  rdat;

  logic        bv = 1'b0, bw = 1'b0;
  logic        br, b1r, brv, brid, bbsy;
  logic [15:0] ba = '0;
  logic [7:0]  bd = '0, brdat;

  logic [1:0]  cs_n, sck, mosi, miso;

  spi_mem_arbiter #(.ADDR_W(16), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_we(r0w),
    .req0_addr(r0a), .req0_wdata(r0d),
    .req1_valid(r1v), .req1_ready(r1r), .req1_we(r1w),
    .req1_addr(r1a), .req1_wdata(r1d),
    .resp_valid(rv), .resp_id(rid), .resp_rdata(rdat), .busy(bsy),
    .spi_cs_n(cs_n[0]), .spi_sck(sck[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_mem_arbiter #(.ADDR_W(16), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(bv), .req0_ready(br), .req0_we(bw),
    .req0_addr(ba), .req0_wdata(bd),
    .req1_valid(1'b0), .req1_ready(b1r), .req1_we(1'b0),
    .req1_addr(16'h0000), .req1_wdata(8'h00),
    .resp_valid(brv), .resp_id(brid), .resp_rdata(brdat), .busy(bbsy),
    .spi_cs_n(cs_n[1]), .spi_sck(sck[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  logic [7:0] mem [logic [15:0]];

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_ram
    int          n    = 0;
    logic [31:0] fr   = '0;
    logic [31:0] last = '0;
    logic [7:0]  rd   = '0;
    logic        so   = 1'b0;
    assign miso[g] = so;

    always @(negedge cs_n[g] or posedge sck[g]) begin
      if (!sck[g]) n = 0;
      else if (!cs_n[g]) begin
        fr = {fr[30:0], mosi[g]};
        n++;
        if (n == 24) rd = mem_rd(fr[15:0]);
      end
    end

    always @(negedge sck[g] or posedge cs_n[g]) begin
      if (cs_n[g]) begin
        so = 1'b0;
        if (n == 32) last = fr;
      end else if (n >= 24 && n < 32) begin
        so = rd[31 - n];
      end
    end

    if (g == 0) begin : g_wr
      always @(posedge cs_n[g])
        if (n == 32 && fr[31:24] == 8'h02) mem[fr[23:8]] = fr[7:0];
    end
  end

  typedef struct {
    logic       id;
    logic [7:0] rd;
    int         acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] prev0 = 8'h00;
  logic [7:0] prev1 = 8'h00;

  // expected responses are queued at the accept cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev0 = 8'h00;
      prev1 = 8'h00;
    end else begin
      if (r0v && r0r) begin
        if (!r0w) prev0 = mem_rd(r0a);
        e.id = 1'b0; e.rd = prev0; e.acc = cyc;
        q0.push_back(e);
      end
      if (r1v && r1r) begin
        if (!r1w) prev0 = mem_rd(r1a);
        e.id = 1'b1; e.rd = prev0; e.acc = cyc;
        q0.push_back(e);
      end
      if (bv && br) begin
        if (!bw) prev1 = mem_rd(ba);
        e.id = 1'b0; e.rd = prev1; e.acc = cyc;
        q1.push_back(e);
      end
    end
  end

  task automatic wait_rv(input bit d1, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((d1 ? brv : rv) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [15:0] a,
                       input logic [7:0] d, output int acc);
    logic rdy;
    acc = -1;
    @(posedge clk); #1;
    case (p)
      0: begin r0v = 1'b1; r0w = we; r0a = a; r0d = d; end
      1: begin r1v = 1'b1; r1w = we; r1a = a; r1d = d; end
      default: begin bv = 1'b1; bw = we; ba = a; bd = d; end
    endcase
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rdy = (p == 0) ? r0r : (p == 1) ? r1r : br;
      if (rdy === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    case (p)
      0: r0v = 1'b0;
      1: r1v = 1'b0;
      default: bv = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (cs_n !== 2'b11) begin
      n_fail++; $display("FAIL reset_cs_n: got %b want 11", cs_n);
    end
    n_chk++;
    if (sck !== 2'b00 || mosi !== 2'b00) begin
      n_fail++; $display("FAIL reset_sck_mosi: got %b/%b want 00/00", sck, mosi);
    end
    n_chk++;
    if (rv !== 1'b0 || rid !== 1'b0 || bsy !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got v=%b id=%b busy=%b want 0 0 0", rv, rid, bsy);
    end
    n_chk++;
    if (rdat !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00", rdat);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (r0r !== 1'b0 || r1r !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_ready: got %b%b want 00", r0r, r1r);
    end
  endtask

  task automatic test_read();
    int acc, t, bad;
    exp_t e;
    mem[16'h1234] = 8'hA5;
    issue(0, 1'b0, 16'h1234, 8'h00, acc);
    n_chk++;
    if (acc < 0) begin n_fail++; $display("FAIL read_accept: got none want accept"); end
    @(negedge clk);
    n_chk++;
    if (cs_n[0] !== 1'b0) begin
      n_fail++; $display("FAIL read_cs_fall: got %b want 0", cs_n[0]);
    end
    wait_rv(0, t);
    n_chk++;
    if (t < 0 || q0.size() == 0) begin
      n_fail++; $display("FAIL read_resp: got none want response");
    end else begin
      e = q0.pop_front();
      n_chk++;
      if (t != e.acc + 129) begin
        n_fail++; $display("FAIL read_latency: got %0d want %0d", t - e.acc, 129);
      end
      n_chk++;
      if (rid !== e.id || rdat !== e.rd) begin
        n_fail++; $display("FAIL read_data: got id=%b %h want id=%b %h", rid, rdat, e.id, e.rd);
      end
    end
    n_chk++;
    if (g_ram[0].last !== 32'h03123400) begin
      n_fail++; $display("FAIL read_mosi: got %h want 03123400", g_ram[0].last);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (cs_n[0] !== 1'b1 || mosi[0] !== 1'b0 || sck[0] !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL read_gap: got %0d bad gap cycles want 0", bad);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int acc, t;
    exp_t e;
    issue(1, 1'b1, 16'h00FF, 8'h3C, acc);
    wait_rv(0, t);
    n_chk++;
    if (t < 0 || q0.size() == 0) begin
      n_fail++; $display("FAIL write_resp: got none want response");
    end else begin
      e = q0.pop_front();
      n_chk++;
      if (rid !== 1'b1 || rid !== e.id) begin
        n_fail++; $display("FAIL write_id: got %b want 1", rid);
      end
      n_chk++;
      if (rdat !== e.rd) begin
        n_fail++; $display("FAIL write_rdata_held: got %h want %h", rdat, e.rd);
      end
    end
    n_chk++;
    if (g_ram[0].last !== 32'h0200FF3C) begin
      n_fail++; $display("FAIL write_mosi: got %h want 0200FF3C", g_ram[0].last);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_contention();
    int t;
    exp_t e;
    logic [3:0] ord;
`ifdef SPI_ARB_FIXED_PRIO_EN
    ord = 4'b0000;
`else
    ord = 4'b1010;
`endif
    mem[16'h0100] = 8'h11;
    mem[16'h0200] = 8'h22;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r0v = 1'b1; r0w = 1'b0; r0a = 16'h0100;
    r1v = 1'b1; r1w = 1'b0; r1a = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      wait_rv(0, t);
      n_chk++;
      if (t < 0 || q0.size() == 0) begin
        n_fail++; $display("FAIL contention_resp%0d: got none want response", k);
      end else begin
        e = q0.pop_front();
        n_chk++;
        if (rid !== ord[k] || e.id !== ord[k] || rdat !== e.rd) begin
          n_fail++;
          $display("FAIL contention_grant%0d: got id=%b %h want id=%b %h", k, rid, rdat, ord[k], e.rd);
        end
      end
    end
    @(posedge clk); #1;
    r0v = 1'b0;
    r1v = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (q0.size() != 0) begin
      n_fail++; $display("FAIL contention_extra: got %0d queued want 0", q0.size());
    end
  endtask

  task automatic test_back_to_back();
    int a, b, t1, t2, bad;
    exp_t e;
    a = -1; b = -1; t1 = -1; bad = 0;
    @(posedge clk); #1;
    r0v = 1'b1; r0w = 1'b0; r0a = 16'h0100;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (r0r === 1'b1) begin a = cyc; break; end
    end
    if (bsy !== 1'b1) bad++;
    for (int i = 0; i < 400 && a >= 0; i++) begin
      @(negedge clk);
      if (rv === 1'b1) t1 = cyc;
      if (r0r === 1'b1) begin b = cyc; break; end
      if (bsy !== 1'b1) bad++;
    end
    @(posedge clk); #1;
    r0v = 1'b0;
    n_chk++;
    if (a < 0 || b != a + 133) begin
      n_fail++; $display("FAIL b2b_second_accept: got %0d want %0d", b - a, 133);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL b2b_busy: got %0d low cycles want 0", bad);
    end
    n_chk++;
    if (q0.size() == 0 || t1 < 0) begin
      n_fail++; $display("FAIL b2b_resp1: got none want response");
    end else begin
      e = q0.pop_front();
      n_chk++;
      if (t1 != e.acc + 129 || rdat !== 8'h11) begin
        n_fail++; $display("FAIL b2b_resp1_data: got t=%0d %h want t=%0d 11", t1, rdat, e.acc + 129);
      end
    end
    wait_rv(0, t2);
    n_chk++;
    if (t2 < 0 || q0.size() == 0) begin
      n_fail++; $display("FAIL b2b_resp2: got none want response");
    end else begin
      e = q0.pop_front();
      n_chk++;
      if (t2 != e.acc + 129 || rdat !== e.rd) begin
        n_fail++; $display("FAIL b2b_resp2_data: got t=%0d %h want t=%0d %h", t2, rdat, e.acc + 129, e.rd);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int acc, t, nrv;
    exp_t e;
    issue(0, 1'b0, 16'h1234, 8'h00, acc);
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (cs_n[0] !== 1'b1 || sck[0] !== 1'b0 || rv !== 1'b0) begin
      n_fail++; $display("FAIL midreset_abort: got cs=%b sck=%b v=%b want 1 0 0", cs_n[0], sck[0], rv);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    nrv = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (rv === 1'b1) nrv++;
    end
    n_chk++;
    if (nrv != 0) begin
      n_fail++; $display("FAIL midreset_no_resp: got %0d pulses want 0", nrv);
    end
    @(posedge clk); #1;
    r1v = 1'b1; r1w = 1'b0; r1a = 16'h0200;
    @(negedge clk);
    n_chk++;
    if (r1r !== 1'b1) begin
      n_fail++; $display("FAIL midreset_idle_accept: got ready=%b want 1", r1r);
    end
    @(posedge clk); #1;
    r1v = 1'b0;
    wait_rv(0, t);
    n_chk++;
    if (t < 0 || q0.size() == 0) begin
      n_fail++; $display("FAIL midreset_resp: got none want response");
    end else begin
      e = q0.pop_front();
      n_chk++;
      if (rid !== 1'b1 || rdat !== 8'h22 || t != e.acc + 129) begin
        n_fail++; $display("FAIL midreset_data: got id=%b %h want id=1 22", rid, rdat);
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_clkdiv1();
    int acc, t, bad;
    exp_t e;
    mem[16'h0001] = 8'h5A;
    issue(2, 1'b0, 16'h0001, 8'h00, acc);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sck[1] !== 1'(i % 2)) bad++;
    end
    n_chk++;
    if (acc < 0 || bad != 0) begin
      n_fail++; $display("FAIL div1_sck: got %0d bad phases want 0", bad);
    end
    wait_rv(1, t);
    n_chk++;
    if (t < 0 || q1.size() == 0) begin
      n_fail++; $display("FAIL div1_resp: got none want response");
    end else begin
      e = q1.pop_front();
      n_chk++;
      if (t != e.acc + 65) begin
        n_fail++; $display("FAIL div1_latency: got %0d want 65", t - e.acc);
      end
      n_chk++;
      if (brdat !== 8'h5A || brdat !== e.rd || brid !== 1'b0) begin
        n_fail++; $display("FAIL div1_data: got id=%b %h want id=0 5a", brid, brdat);
      end
    end
    n_chk++;
    if (g_ram[1].last !== 32'h03000100) begin
      n_fail++; $display("FAIL div1_mosi: got %h want 03000100", g_ram[1].last);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
